// File: rtl/conv_mac_pkg.sv
// Shared FSM encoding and lane-packing helpers for the conv_mac_vec MAC.
package conv_mac_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACC   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

    // Low bit of lane i inside a packed LANES*WIDTH operand bus.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    // Tree result width: a full-precision 16-lane sum of (W+1)x(W+1) signed
    // products fits in 2W+5 bits, and never narrower than the accumulator.
    function automatic int tree_w(input int width, input int acc_width);
        return (acc_width > 2 * width + 5) ? acc_width : 2 * width + 5;
    endfunction

endpackage

// File: rtl/conv_mac_tree.sv
// Per-lane multiply with lane enable, reduced by a binary adder tree at full precision.
module conv_mac_tree
    import conv_mac_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int SIGNED_MUL = 1
) (
    input  logic [LANES*WIDTH-1:0]                    a,
    input  logic [LANES*WIDTH-1:0]                    b,
    input  logic [LANES-1:0]                          lane_en,
    output logic signed [tree_w(WIDTH, ACC_WIDTH)-1:0] sum
);

    localparam int TW = tree_w(WIDTH, ACC_WIDTH);
    localparam int PW = 2 * WIDTH + 2;

    // Heap-ordered tree: leaves at [LANES +: LANES], node k sums 2k and 2k+1.
    logic signed [TW-1:0] node [1:2*LANES-1];

    genvar i, k;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            localparam int LO = lane_lo(i, WIDTH);
            logic signed [WIDTH:0] ax, bx;
            logic signed [PW-1:0]  prod;

            // One extra bit lets signed and unsigned operands share a signed multiplier.
            assign ax   = (SIGNED_MUL != 0) ? {a[LO+WIDTH-1], a[LO +: WIDTH]} : {1'b0, a[LO +: WIDTH]};
            assign bx   = (SIGNED_MUL != 0) ? {b[LO+WIDTH-1], b[LO +: WIDTH]} : {1'b0, b[LO +: WIDTH]};
            assign prod = ax * bx;
            assign node[LANES+i] = lane_en[i] ? {{(TW-PW){prod[PW-1]}}, prod} : '0;
        end

        for (k = 1; k < LANES; k++) begin : g_add
            assign node[k] = node[2*k] + node[2*k+1];
        end
    endgenerate

    assign sum = node[1];

endmodule

// File: rtl/conv_mac_vec.sv
// Windowed vector MAC: tree stage, accumulate stage, held result with handshake.
// Define CONV_MAC_SAT_EN to clamp the accumulator and report out_ovf; default wraps.
module conv_mac_vec
    import conv_mac_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int SIGNED_MUL = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [LANES-1:0]       lane_en,
    input  logic [LANES*WIDTH-1:0] a_in,
    input  logic [LANES*WIDTH-1:0] b_in,
    input  logic                   bias_valid,
    input  logic [ACC_WIDTH-1:0]   bias_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_sum,
    output logic [CNT_WIDTH-1:0]   out_beats,
    output logic                   out_ovf,
    output logic                   err_proto
);

    localparam int TW = tree_w(WIDTH, ACC_WIDTH);
    localparam int SW = TW + 2;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t state, state_nx;

    logic                  take, keep, bad;
    logic signed [TW-1:0]  tree_sum;
    logic                  s1_vld, s1_first;
    logic signed [TW-1:0]  s1_sum;
    logic [ACC_WIDTH-1:0]  s1_bias;
    logic [ACC_WIDTH-1:0]  acc, acc_nx, base;
    logic signed [SW-1:0]  base_x, sum_x;
    logic [CNT_WIDTH-1:0]  cnt;

    conv_mac_tree #(
        .WIDTH      (WIDTH),
        .LANES      (LANES),
        .ACC_WIDTH  (ACC_WIDTH),
        .SIGNED_MUL (SIGNED_MUL)
    ) u_tree (
        .a       (a_in),
        .b       (b_in),
        .lane_en (lane_en),
        .sum     (tree_sum)
    );

    assign in_ready = (state == ST_IDLE) || (state == ST_ACC);
    assign take     = in_valid && in_ready;
    // Beats outside a window are dropped; in_first inside a window restarts it.
    assign keep     = take && ((state == ST_ACC) || in_first);
    assign bad      = take && (((state == ST_IDLE) && !in_first) || ((state == ST_ACC) && in_first));

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (take && in_first) state_nx = in_last ? ST_DRAIN : ST_ACC;
            ST_ACC:   if (take && in_last)  state_nx = ST_DRAIN;
            ST_DRAIN: state_nx = ST_HOLD;
            ST_HOLD:  if (out_ready)        state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            s1_vld    <= 1'b0;
            s1_first  <= 1'b0;
            s1_sum    <= '0;
            s1_bias   <= '0;
            acc       <= '0;
            cnt       <= '0;
            err_proto <= 1'b0;
        end else begin
            state  <= state_nx;
            s1_vld <= keep;
            if (keep) begin
                s1_sum   <= tree_sum;
                s1_first <= in_first;
                s1_bias  <= (in_first && bias_valid) ? bias_in : '0;
                cnt      <= in_first ? CNT_WIDTH'(1) : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);
            end
            if (s1_vld)
                acc <= acc_nx;
            if (bad)
                err_proto <= 1'b1;
        end
    end

    // Accumulate in a widened domain so overflow is visible before truncation.
    always_comb begin
        base   = s1_first ? s1_bias : acc;
        base_x = (SIGNED_MUL != 0) ? {{(SW-ACC_WIDTH){base[ACC_WIDTH-1]}}, base}
                                   : {{(SW-ACC_WIDTH){1'b0}}, base};
        sum_x  = base_x + {{(SW-TW){s1_sum[TW-1]}}, s1_sum};
    end

`ifdef CONV_MAC_SAT_EN
    localparam logic signed [SW-1:0] ONE    = 1;
    localparam logic signed [SW-1:0] ZERO   = 0;
    localparam logic signed [SW-1:0] SAT_HI = (SIGNED_MUL != 0) ? ((ONE <<< (ACC_WIDTH-1)) - ONE)
                                                                : ((ONE <<< ACC_WIDTH) - ONE);
    localparam logic signed [SW-1:0] SAT_LO = (SIGNED_MUL != 0) ? (ZERO - (ONE <<< (ACC_WIDTH-1)))
                                                                : ZERO;
    logic sat_hit, ovf;

    always_comb begin
        sat_hit = 1'b0;
        acc_nx  = sum_x[ACC_WIDTH-1:0];
        if (sum_x > SAT_HI) begin
            sat_hit = 1'b1;
            acc_nx  = SAT_HI[ACC_WIDTH-1:0];
        end else if (sum_x < SAT_LO) begin
            sat_hit = 1'b1;
            acc_nx  = SAT_LO[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (s1_vld)
            ovf <= s1_first ? sat_hit : (ovf | sat_hit);
    end

    assign out_ovf = ovf;
`else
    logic unused_hi;

    // Wrap mode keeps only the low ACC_WIDTH bits of the widened sum.
    assign acc_nx    = sum_x[ACC_WIDTH-1:0];
    assign unused_hi = ^sum_x[SW-1:ACC_WIDTH];
    assign out_ovf   = 1'b0;
`endif

    assign out_valid = (state == ST_HOLD);
    assign out_sum   = acc;
    assign out_beats = cnt;

endmodule

// File: tb/tb_conv_mac_vec.sv
// Directed bench for conv_mac_vec: default instance plus an ACC_WIDTH=16 instance.
module tb_conv_mac_vec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
    logic [3:0]  lane_en = 4'h0;
    logic [31:0] a_in = '0, b_in = '0;
    logic        bias_valid = 1'b0;
    logic [31:0] bias_in = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_ovf, err_proto;
    logic [31:0] out_sum;
    logic [7:0]  out_beats;

    logic        in_ready16, out_valid16, out_ovf16, err16;
    logic [15:0] out_sum16, bias16;
    logic [7:0]  out_beats16;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign bias16 = bias_in[15:0];

    conv_mac_vec dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last), .lane_en(lane_en),
        .a_in(a_in), .b_in(b_in), .bias_valid(bias_valid), .bias_in(bias_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_beats(out_beats), .out_ovf(out_ovf), .err_proto(err_proto)
    );

    conv_mac_vec #(.ACC_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .in_first(in_first), .in_last(in_last), .lane_en(lane_en),
        .a_in(a_in), .b_in(b_in), .bias_valid(bias_valid), .bias_in(bias16),
        .out_valid(out_valid16), .out_ready(out_ready), .out_sum(out_sum16),
        .out_beats(out_beats16), .out_ovf(out_ovf16), .err_proto(err16)
    );

    typedef struct {
        logic        bv;
        logic [31:0] bias;
        logic [3:0]  en;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_sum;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic beat(input logic f, input logic l, input logic bv, input logic [31:0] bias,
                        input logic [3:0] en, input logic [31:0] a, input logic [31:0] b);
        in_first = f; in_last = l; bias_valid = bv; bias_in = bias;
        lane_en = en; a_in = a; b_in = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; bias_valid = 1'b0;
    endtask

    // Called right after the last beat is accepted: DRAIN cycle, then HOLD.
    task automatic finish_window(input string name, input logic [31:0] exp_sum, input logic [7:0] exp_beats);
        @(negedge clk);
        check({name, "_drain_valid"}, {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({name, "_sum"}, out_sum, exp_sum);
        check({name, "_beats"}, {24'b0, out_beats}, {24'b0, exp_beats});
        check({name, "_ovf"}, {31'b0, out_ovf}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 32'd0,          4'hF, 32'h04030201, 32'h08070605, 32'd70};
        tbl[1] = '{1'b1, 32'd100,        4'hF, 32'h04030201, 32'h08070605, 32'd170};
        tbl[2] = '{1'b0, 32'd0,          4'h5, 32'h04030201, 32'h08070605, 32'd26};
        tbl[3] = '{1'b1, 32'd7,          4'h0, 32'h04030201, 32'h08070605, 32'd7};
        tbl[4] = '{1'b0, 32'd0,          4'hF, 32'hFFFFFFFF, 32'h02020202, 32'hFFFFFFF8};
        tbl[5] = '{1'b0, 32'd0,          4'hF, 32'h80808080, 32'h7F7F7F7F, 32'hFFFF0200};
        tbl[6] = '{1'b1, 32'hFFFFFFF6,   4'hF, 32'h01010101, 32'h03030303, 32'd2};
        tbl[7] = '{1'b0, 32'd999,        4'h8, 32'h02020202, 32'h02020202, 32'd4};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_sum", out_sum, 32'd0);
        check("rst_out_beats", {24'b0, out_beats}, 32'd0);
        check("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
        check("rst_err", {31'b0, err_proto}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Single-beat windows from the table
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, 1'b1, tbl[i].bv, tbl[i].bias, tbl[i].en, tbl[i].a, tbl[i].b);
            finish_window($sformatf("tbl%0d", i), tbl[i].exp_sum, 8'd1);
        end

        // Two-beat window; bias on the second beat must be ignored
        beat(1'b1, 1'b0, 1'b1, 32'd100, 4'hF, 32'h04030201, 32'h08070605);
        beat(1'b0, 1'b1, 1'b1, 32'd500, 4'hF, 32'h01010101, 32'h02020202);
        finish_window("two_beat", 32'd178, 8'd2);

        // -128 * -128 on all lanes: fits 32 bits, overflows 16 bits
        beat(1'b1, 1'b1, 1'b0, 32'd0, 4'hF, 32'h80808080, 32'h80808080);
        @(negedge clk);
        @(negedge clk);
        check("big_sum32", out_sum, 32'h00010000);
        check("big_ovf32", {31'b0, out_ovf}, 32'd0);
        check("big_valid16", {31'b0, out_valid16}, 32'd1);
`ifdef CONV_MAC_SAT_EN
        check("big_sum16", {16'b0, out_sum16}, 32'd32767);
        check("big_ovf16", {31'b0, out_ovf16}, 32'd1);
`else
        check("big_sum16", {16'b0, out_sum16}, 32'd0);
        check("big_ovf16", {31'b0, out_ovf16}, 32'd0);
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Backpressure: hold result 5 cycles while a beat is offered
        beat(1'b1, 1'b1, 1'b0, 32'd0, 4'hF, 32'h04030201, 32'h08070605);
        @(negedge clk);
        in_first = 1'b1; in_last = 1'b1; lane_en = 4'hF;
        a_in = 32'h01010101; b_in = 32'h01010101; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_valid%0d", c), {31'b0, out_valid}, 32'd1);
            check($sformatf("bp_sum%0d", c), out_sum, 32'd70);
            check($sformatf("bp_in_ready%0d", c), {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        check("bp_release_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        finish_window("bp_next", 32'd4, 8'd1);

        // Beat counter saturation: 301 beats with lanes disabled
        beat(1'b1, 1'b0, 1'b0, 32'd0, 4'h0, 32'h01010101, 32'h01010101);
        for (int n = 0; n < 299; n++)
            beat(1'b0, 1'b0, 1'b0, 32'd0, 4'h0, 32'h01010101, 32'h01010101);
        beat(1'b0, 1'b1, 1'b0, 32'd0, 4'h0, 32'h01010101, 32'h01010101);
        finish_window("sat_cnt", 32'd0, 8'd255);

        // Reset after 2 of 3 beats discards the window
        beat(1'b1, 1'b0, 1'b0, 32'd0, 4'hF, 32'h04030201, 32'h08070605);
        beat(1'b0, 1'b0, 1'b0, 32'd0, 4'hF, 32'h04030201, 32'h08070605);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_sum", out_sum, 32'd0);
        check("mid_rst_beats", {24'b0, out_beats}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        begin
            logic saw = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                saw = saw | out_valid;
            end
            check("mid_rst_no_valid", {31'b0, saw}, 32'd0);
        end
        beat(1'b1, 1'b1, 1'b0, 32'd0, 4'hF, 32'h04030201, 32'h08070605);
        finish_window("after_rst", 32'd70, 8'd1);

        // Protocol errors: stray beat in IDLE, then restart inside a window
        check("err_before", {31'b0, err_proto}, 32'd0);
        beat(1'b0, 1'b1, 1'b0, 32'd0, 4'hF, 32'h01010101, 32'h01010101);
        @(negedge clk);
        check("err_stray", {31'b0, err_proto}, 32'd1);
        check("err_stray16", {31'b0, err16}, 32'd1);
        check("err_stray_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        check("err_stray_no_valid", {31'b0, out_valid}, 32'd0);
        beat(1'b1, 1'b0, 1'b0, 32'd0, 4'hF, 32'h05050505, 32'h05050505);
        beat(1'b0, 1'b0, 1'b0, 32'd0, 4'hF, 32'h01010101, 32'h01010101);
        beat(1'b1, 1'b0, 1'b1, 32'd100, 4'hF, 32'h04030201, 32'h08070605);
        beat(1'b0, 1'b1, 1'b0, 32'd0, 4'hF, 32'h01010101, 32'h02020202);
        finish_window("restart", 32'd178, 8'd2);
        check("err_sticky", {31'b0, err_proto}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("err_cleared", {31'b0, err_proto}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
